// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent debounce channels. Each channel synchronises
// a raw input, accepts a level change only after SHORT_TICKS stable samples,
// and derives press/release pulses, a release-toggle latch and a long-press
// pulse/latch. Every output comes straight from a flop.
module debounce_bank #(
    parameter int                N_CH        = 6,
    parameter int                CNT_W       = 28,
    parameter int                SHORT_TICKS = 10000,
    parameter int                LONG_TICKS  = 250000000,
    parameter logic [N_CH-1:0]   TOGGLE_MASK = {N_CH{1'b1}},
    parameter logic [N_CH-1:0]   LONG_MASK   = {N_CH{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] toggle_out,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] long_state
);

    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_TICKS - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             sync_p0;
        logic             sync_p1;
        logic             lvl;
        logic             fired;
        logic             tog;
        logic             lst;
        logic             press_r;
        logic             release_r;
        logic             long_r;
        logic [CNT_W-1:0] dcnt;
        logic [CNT_W-1:0] hcnt;
        logic             flip;
        logic             long_hit;

        // Event decode on pre-edge state: accepted level change and long-press threshold.
        always_comb begin
            flip     = (sync_p1 != lvl) && (dcnt == SHORT_LAST);
            long_hit = lvl && !fired && (hcnt == LONG_LAST);
        end

        // --- stage p0/p1: two-flop synchroniser for the asynchronous pin
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_p0 <= 1'b0;
                sync_p1 <= 1'b0;
            end else begin
                sync_p0 <= raw_in[i];
                sync_p1 <= sync_p0;
            end
        end

        // --- debounce: any sample matching lvl restarts the stability count
        always_ff @(posedge clk) begin
            if (reset) begin
                lvl       <= 1'b0;
                dcnt      <= '0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                press_r   <= flip && sync_p1;
                release_r <= flip && !sync_p1;
                if (sync_p1 == lvl) begin
                    dcnt <= '0;
                end else if (flip) begin
                    lvl  <= sync_p1;
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + CNT_ONE;
                end
            end
        end

        // Long-press timer: fires once per press, then parks until release.
        always_ff @(posedge clk) begin
            if (reset) begin
                hcnt   <= '0;
                fired  <= 1'b0;
                long_r <= 1'b0;
            end else begin
                long_r <= LONG_MASK[i] && long_hit;
                if (!lvl) begin
                    hcnt  <= '0;
                    fired <= 1'b0;
                end else if (long_hit) begin
                    fired <= 1'b1;
                    hcnt  <= '0;
                end else if (!fired) begin
                    hcnt <= hcnt + CNT_ONE;
                end
            end
        end

        // Toggle and long-state latches; clear wins over a same-edge event.
        always_ff @(posedge clk) begin
            if (reset || clear) begin
                tog <= 1'b0;
                lst <= 1'b0;
            end else begin
                if (TOGGLE_MASK[i] && flip && !sync_p1) begin
                    tog <= ~tog;
                end
                if (LONG_MASK[i] && long_hit) begin
                    lst <= ~lst;
                end
            end
        end

        assign level_out[i]     = lvl;
        assign press_pulse[i]   = press_r;
        assign release_pulse[i] = release_r;
        assign toggle_out[i]    = tog;
        assign long_pulse[i]    = long_r;
        assign long_state[i]    = lst;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed scenarios for a 4-channel bank with short
// debounce/long-press timing; expected values are hand-derived edge numbers.
module tb_debounce_bank;

    localparam int              N_CH        = 4;
    localparam int              CNT_W       = 8;
    localparam int              SHORT_TICKS = 4;
    localparam int              LONG_TICKS  = 20;
    localparam logic [N_CH-1:0] TOGGLE_MASK = 4'b0101;
    localparam logic [N_CH-1:0] LONG_MASK   = 4'b0001;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] toggle_out;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] long_state;

    int n_cmp = 0;
    int n_err = 0;

    debounce_bank #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .SHORT_TICKS (SHORT_TICKS),
        .LONG_TICKS  (LONG_TICKS),
        .TOGGLE_MASK (TOGGLE_MASK),
        .LONG_MASK   (LONG_MASK)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .raw_in        (raw_in),
        .level_out     (level_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .toggle_out    (toggle_out),
        .long_pulse    (long_pulse),
        .long_state    (long_state)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset  = 1'b1;
        clear  = 1'b0;
        raw_in = '0;

        // Reset for 3 cycles, then one cycle after release.
        for (int e = 0; e < 3; e++) begin
            tick();
            chk_eq($sformatf("rst_outs c%0d", e),
                   {level_out, press_pulse, release_pulse, toggle_out, long_pulse, long_state}, 0);
        end
        reset = 1'b0;
        tick();
        chk_eq("post_rst_outs",
               {level_out, press_pulse, release_pulse, toggle_out, long_pulse, long_state}, 0);
        idle(3);

        // Glitch of 3 cycles on channel 0 never reaches the outputs.
        raw_in = 4'b0001;
        for (int e = 0; e < 14; e++) begin
            tick();
            chk_eq($sformatf("glitch_ch0 e%0d", e),
                   {level_out[0], press_pulse[0], release_pulse[0], toggle_out[0], long_pulse[0]}, 0);
            if (e == 2) raw_in = 4'b0000;
        end
        idle(4);

        // Channels 0 and 1 pressed for 10 cycles: press at edge 5, release at edge 15.
        raw_in = 4'b0011;
        for (int e = 0; e < 24; e++) begin
            tick();
            chk_eq($sformatf("t3_level e%0d", e), level_out, (e >= 5 && e < 15) ? 4'b0011 : 4'b0000);
            chk_eq($sformatf("t3_press e%0d", e), press_pulse, (e == 5) ? 4'b0011 : 4'b0000);
            chk_eq($sformatf("t3_release e%0d", e), release_pulse, (e == 15) ? 4'b0011 : 4'b0000);
            chk_eq($sformatf("t3_toggle e%0d", e), toggle_out, (e >= 15) ? 4'b0001 : 4'b0000);
            chk_eq($sformatf("t3_long e%0d", e), long_pulse, 0);
            if (e == 9) raw_in = 4'b0000;
        end
        idle(4);

        // Channel 0 held 40 cycles: single long pulse at edge 25, release at edge 45.
        raw_in = 4'b0001;
        for (int e = 0; e < 50; e++) begin
            tick();
            chk_eq($sformatf("t4_long e%0d", e), long_pulse, (e == 25) ? 4'b0001 : 4'b0000);
            chk_eq($sformatf("t4_lstate e%0d", e), long_state, (e >= 25) ? 4'b0001 : 4'b0000);
            chk_eq($sformatf("t4_level e%0d", e), level_out, (e >= 5 && e < 45) ? 4'b0001 : 4'b0000);
            chk_eq($sformatf("t4_release e%0d", e), release_pulse, (e == 45) ? 4'b0001 : 4'b0000);
            chk_eq($sformatf("t4_toggle e%0d", e), toggle_out, (e < 45) ? 4'b0001 : 4'b0000);
            if (e == 39) raw_in = 4'b0000;
        end
        idle(4);

        // Clear on the release edge of channel 2: pulse survives, latches are cleared.
        raw_in = 4'b0100;
        for (int e = 0; e < 21; e++) begin
            tick();
            chk_eq($sformatf("t5_level e%0d", e), level_out, (e >= 5 && e < 15) ? 4'b0100 : 4'b0000);
            chk_eq($sformatf("t5_release e%0d", e), release_pulse, (e == 15) ? 4'b0100 : 4'b0000);
            chk_eq($sformatf("t5_toggle e%0d", e), toggle_out, 0);
            chk_eq($sformatf("t5_lstate e%0d", e), long_state, (e < 15) ? 4'b0001 : 4'b0000);
            if (e == 9) raw_in = 4'b0000;
            if (e == 14) clear = 1'b1;
            if (e == 15) clear = 1'b0;
        end
        idle(4);

        // Reset at edge 3 while channel 0 is being debounced: restart, flip at edge 9.
        raw_in = 4'b0001;
        for (int e = 0; e < 16; e++) begin
            tick();
            chk_eq($sformatf("t6_level e%0d", e), level_out, (e >= 9) ? 4'b0001 : 4'b0000);
            chk_eq($sformatf("t6_press e%0d", e), press_pulse, (e == 9) ? 4'b0001 : 4'b0000);
            if (e == 3)
                chk_eq("t6_rst_outs",
                       {level_out, press_pulse, release_pulse, toggle_out, long_pulse, long_state}, 0);
            if (e == 2) reset = 1'b1;
            if (e == 3) reset = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
